mlx90640_subpage_merger: RTL and testbench
==========================================

Name: mlx90640_subpage_merger

Overview:
Sequences assembly of full 32x24 MLX90640 frames from the sensor's two interleaved subpage readouts.
- Accepts a pixel stream from the I2C frame reader, tagged with subpage ID.
- Queries the external async subpage-pattern ROMs to decide whether each pixel is valid for the tagged subpage.
- Writes only valid pixels into the frame buffer.
- Signals completion when both subpages of a frame have been merged.
- Sits between the I2C reader and the frame-buffer BRAM; the subpage-pattern ROM wrapper is instantiated beside it at top level.

Parameters:
- WIDTH, 16, pixel data width.
- DEPTH, 768, pixels per frame (32*24).
- ADDRW, $clog2(DEPTH), local; address width.
- HALF, DEPTH/2, local; expected writes per subpage.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  merger can accept a pixel.
- s_addr  in  ADDRW  pixel index 0..DEPTH-1.
- s_data  in  WIDTH  raw pixel word.
- s_subpage  in  1  subpage ID of this readout.
- s_last  in  1  final pixel of this subpage readout.
- pass_all  in  1  bypass the ROM mask; write every pixel.
- rom_addr_pg0  out  ADDRW  address to the subpage-0 pattern ROM.
- rom_data_pg0  in  1  pattern bit, combinational return.
- rom_addr_pg1  out  ADDRW  address to the subpage-1 pattern ROM.
- rom_data_pg1  in  1  pattern bit, combinational return.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDRW  frame-buffer address.
- wr_data  out  WIDTH  frame-buffer data.
- frame_done  out  1  one-cycle pulse when a full frame is merged.
- frame_cnt  out  8  number of completed frames, wraps at 255->0.
- err_count  out  1  one-cycle pulse when a subpage ended with write count != HALF.

Behaviour:
- Reset: all outputs 0; state IDLE; got_pg0 = got_pg1 = 0; both write counters 0.
- ROM addressing: rom_addr_pg0 = rom_addr_pg1 = s_addr, combinational.
- Mask: sel = (s_subpage ? rom_data_pg1 : rom_data_pg0) | pass_all.
- Handshake: a pixel is accepted when s_valid & s_ready. s_ready = 1 in IDLE and COLLECT, 0 in DONE.
- Write latency: 1 cycle. On an accepted pixel with sel = 1, the next cycle has wr_en = 1 with wr_addr/wr_data registered from s_addr/s_data. Otherwise wr_en = 0.
- Counters: cnt[s_subpage] increments on each write issued. The counter is ADDRW wide and saturates at DEPTH-1.
- FSM:
  - IDLE: the first accepted pixel goes to COLLECT; cnt[s_subpage] is cleared and counts that pixel.
  - COLLECT, accepted pixel with s_last = 1:
    - err_count pulses next cycle if the final count (including this pixel) != HALF; with pass_all = 1, the comparison is against DEPTH.
    - got[s_subpage] is set.
    - If the other got flag is already set, go to DONE; else stay in COLLECT.
  - COLLECT, subpage ID repeated: an accepted pixel whose subpage already has got set is a start of a new readout. That subpage's got flag and counter are cleared first; the previous partial frame is abandoned and the other subpage is kept.
  - DONE (1 cycle): frame_done = 1, frame_cnt += 1, both got flags and both counters cleared, then go to IDLE. The write for the last pixel appears in the same cycle as frame_done.
- Boundaries:
  - s_addr >= DEPTH: the pixel is accepted and dropped (no write); err_count pulses.
  - s_valid held while in DONE: no acceptance; the pixel is taken in IDLE next cycle.
  - rst mid-frame: counters and flags are cleared; any pending wr_en is squashed in the same cycle rst is sampled.
  - pass_all change: sampled per pixel. Changing it mid-readout is legal; the err_count check uses the pass_all value at the s_last pixel.

Decomposition:
- Shared package mlx90640_pkg holds:
  - MLX_COLS = 32, MLX_ROWS = 24, MLX_PIXELS = 768.
  - typedef logic [9:0] mlx_addr_t.
  - typedef logic [15:0] mlx_pixel_t.
  - typedef enum {IDLE, COLLECT, DONE} merger_state_t.
- No sub-module. The ROM wrapper stays external so that the frame reader or a debug view can share the pattern ROMs.

Test Plan:
1. Chess pattern, subpage 0 then subpage 1, addrs 0..767 each, last on 767 -> exactly 384 writes per subpage. Addr 0 is written only from subpage 0, addr 1 only from subpage 1. frame_done pulses once; frame_cnt = 1; err_count never pulses.
2. pass_all = 1, single subpage-0 readout of 768 pixels -> 768 writes, err_count = 0, no frame_done. Then a subpage-1 readout -> frame_done, frame_cnt = 1.
3. Subpage 0 sent twice (second copy has data + 0x100), then subpage 1 -> one frame_done. Subpage-0 frame-buffer contents match the second copy.
4. Subpage 0 truncated with last at addr 500 -> 250 writes, err_count pulses one cycle after acceptance of addr 500.
5. Random s_valid gaps, plus rst asserted at pixel 300 of subpage 1 -> no wr_en in the cycle after rst. The next complete pair gives frame_cnt = 1.
6. 256 complete frames -> frame_cnt wraps to 0; s_ready = 0 exactly in each frame_done cycle.

Source files
------------

// File: rtl/mlx90640_pkg.sv
// Shared definitions for the MLX90640 frame path.
// Sensor geometry constants, pixel/address word types and the merger FSM state type.
package mlx90640_pkg;

    localparam int MLX_COLS   = 32;
    localparam int MLX_ROWS   = 24;
    localparam int MLX_PIXELS = 768;

    typedef logic [9:0]  mlx_addr_t;
    typedef logic [15:0] mlx_pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } merger_state_t;

endpackage

// File: rtl/mlx90640_subpage_merger.sv
// Merges the two interleaved MLX90640 subpage readouts into one frame buffer.
// Each incoming pixel is checked against the external pattern ROM of its subpage (or
// forced through by pass_all); valid pixels are written to the frame buffer one cycle later.
// A frame completes once both subpages have delivered their last pixel.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_valid/s_ready           pixel stream handshake
//   s_addr/s_data             pixel index and raw word
//   s_subpage/s_last          subpage tag and end-of-readout marker
//   pass_all                  write every pixel regardless of the pattern ROM
//   rom_addr_pg0/rom_data_pg0 subpage-0 pattern ROM (async read)
//   rom_addr_pg1/rom_data_pg1 subpage-1 pattern ROM (async read)
//   wr_en/wr_addr/wr_data     frame-buffer write port
//   frame_done                one-cycle pulse per merged frame
//   frame_cnt                 completed-frame counter, wraps
//   err_count                 one-cycle pulse on a bad write count or out-of-range address
module mlx90640_subpage_merger
    import mlx90640_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 768,
    localparam int ADDRW = $clog2(DEPTH),
    localparam int HALF  = DEPTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [ADDRW-1:0] s_addr,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_subpage,
    input  logic             s_last,
    input  logic             pass_all,
    output logic [ADDRW-1:0] rom_addr_pg0,
    input  logic             rom_data_pg0,
    output logic [ADDRW-1:0] rom_addr_pg1,
    input  logic             rom_data_pg1,
    output logic             wr_en,
    output logic [ADDRW-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             frame_done,
    output logic [7:0]       frame_cnt,
    output logic             err_count
);

    // Counts are compared one bit wider so that a full pass_all readout can reach DEPTH.
    localparam logic [ADDRW:0] DEPTH_W = (ADDRW + 1)'(DEPTH);
    localparam logic [ADDRW:0] HALF_W  = (ADDRW + 1)'(HALF);
    localparam logic [ADDRW:0] SAT_W   = (ADDRW + 1)'(DEPTH - 1);

    merger_state_t               state_q, state_d;
    logic [1:0]                  got_q, got_d;
    logic [1:0][ADDRW-1:0]       cnt_q, cnt_d;
    logic                        wr_en_q;
    logic [ADDRW-1:0]            wr_addr_q;
    logic [WIDTH-1:0]            wr_data_q;
    logic [7:0]                  frame_cnt_q;
    logic                        err_q, err_d;

    logic                        accept;
    logic                        in_range;
    logic                        sel;
    logic                        write;
    logic                        restart;
    logic [ADDRW-1:0]            base;
    logic [ADDRW:0]              fin;
    logic [ADDRW:0]              target;

    assign rom_addr_pg0 = s_addr;
    assign rom_addr_pg1 = s_addr;

    assign s_ready  = (state_q != DONE);
    assign accept   = s_valid & s_ready;
    assign in_range = ({1'b0, s_addr} < DEPTH_W);
    assign sel      = (s_subpage ? rom_data_pg1 : rom_data_pg0) | pass_all;
    assign write    = accept & sel & in_range;

    // A pixel on a subpage that already finished starts a fresh readout of that subpage.
    assign restart = (state_q == IDLE) || got_q[s_subpage];
    assign base    = restart ? '0 : cnt_q[s_subpage];
    assign fin     = {1'b0, base} + {{ADDRW{1'b0}}, write};
    assign target  = pass_all ? DEPTH_W : HALF_W;

    always_comb begin
        state_d = state_q;
        got_d   = got_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    state_d           = COLLECT;
                    got_d[s_subpage]  = 1'b0;
                    cnt_d[s_subpage]  = (fin > SAT_W) ? SAT_W[ADDRW-1:0] : fin[ADDRW-1:0];
                    if (!in_range) begin
                        err_d = 1'b1;
                    end
                    if (s_last) begin
                        got_d[s_subpage] = 1'b1;
                        if (fin != target) begin
                            err_d = 1'b1;
                        end
                        if (got_q[~s_subpage]) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                got_d   = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            got_q       <= '0;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            got_q   <= got_d;
            cnt_q   <= cnt_d;
            wr_en_q <= write;
            err_q   <= err_d;
            if (write) begin
                wr_addr_q <= s_addr;
                wr_data_q <= s_data;
            end
            if (state_q == DONE) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = (state_q == DONE);
    assign frame_cnt  = frame_cnt_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_mlx90640_subpage_merger.sv
// Self-checking bench for mlx90640_subpage_merger with a chess-pattern ROM model and a
// write scoreboard.
module tb_mlx90640_subpage_merger;

    typedef struct packed {
        logic [9:0]  a;
        logic [15:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [9:0]  s_addr;
    logic [15:0] s_data;
    logic        s_subpage;
    logic        s_last;
    logic        pass_all;
    logic [9:0]  rom_addr_pg0;
    logic        rom_data_pg0;
    logic [9:0]  rom_addr_pg1;
    logic        rom_data_pg1;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        err_count;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          wr_seen, wr_hi, err_seen, done_seen;
    logic        chk_ready = 1'b0;
    exp_t        q[$];
    logic [15:0] fb [768];

    always #5 clk = ~clk;

    // Chess readout pattern: subpage = (row + col) & 1.
    function automatic logic chess(input logic [9:0] a);
        return a[5] ^ a[0];
    endfunction

    assign rom_data_pg0 = (chess(rom_addr_pg0) == 1'b0);
    assign rom_data_pg1 = (chess(rom_addr_pg1) == 1'b1);

    mlx90640_subpage_merger #(.WIDTH(16), .DEPTH(768)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_addr       (s_addr),
        .s_data       (s_data),
        .s_subpage    (s_subpage),
        .s_last       (s_last),
        .pass_all     (pass_all),
        .rom_addr_pg0 (rom_addr_pg0),
        .rom_data_pg0 (rom_data_pg0),
        .rom_addr_pg1 (rom_addr_pg1),
        .rom_data_pg1 (rom_data_pg1),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt),
        .err_count    (err_count)
    );

    // Advance one cycle and score whatever the DUT presents just after the edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            wr_seen++;
            if (wr_data[15]) wr_hi++;
            if (wr_addr < 10'd768) fb[wr_addr] = wr_data;
            total_cnt++;
            if (q.size() == 0) begin
                $display("FAIL write_unexpected: got addr=%0d data=%h, required no write",
                         wr_addr, wr_data);
            end else begin
                e = q.pop_front();
                if (wr_addr !== e.a || wr_data !== e.d)
                    $display("FAIL write_match: got addr=%0d data=%h, required addr=%0d data=%h",
                             wr_addr, wr_data, e.a, e.d);
                else pass_cnt++;
            end
        end
        if (err_count === 1'b1) err_seen++;
        if (frame_done === 1'b1) done_seen++;
        if (chk_ready) begin
            total_cnt++;
            if (s_ready !== ~frame_done)
                $display("FAIL ready_vs_done: got s_ready=%b frame_done=%b, required opposite",
                         s_ready, frame_done);
            else pass_cnt++;
        end
    endtask

    task automatic send(input int a, input logic [15:0] d, input logic sp, input logic last);
        logic rdy;
        logic taken;
        taken     = 1'b0;
        s_valid   = 1'b1;
        s_addr    = 10'(a);
        s_data    = d;
        s_subpage = sp;
        s_last    = last;
        for (int i = 0; i < 8 && !taken; i++) begin
            rdy = s_ready;
            if (rdy && a < 768 && (pass_all || chess(10'(a)) == sp)) q.push_back({10'(a), d});
            tick();
            if (rdy) taken = 1'b1;
        end
        if (!taken) begin
            total_cnt++;
            $display("FAIL accept_timeout: got no acceptance of addr=%0d, required within 8", a);
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        rst       = 1'b0;
        wr_seen   = 0;
        wr_hi     = 0;
        err_seen  = 0;
        done_seen = 0;
        for (int i = 0; i < 768; i++) fb[i] = 16'hdead;
    endtask

    task automatic check_int(input string name, input int got, input int req);
        total_cnt++;
        if (got !== req) $display("FAIL %s: got %0d, required %0d", name, got, req);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        s_addr = '0; s_data = '0; s_subpage = 1'b0; pass_all = 1'b0;
        do_reset();
        check_int("reset_wr_en", int'(wr_en), 0);
        check_int("reset_wr_addr", int'(wr_addr), 0);
        check_int("reset_wr_data", int'(wr_data), 0);
        check_int("reset_frame_done", int'(frame_done), 0);
        check_int("reset_frame_cnt", int'(frame_cnt), 0);
        check_int("reset_err_count", int'(err_count), 0);
        check_int("reset_s_ready", int'(s_ready), 1);
    endtask

    task automatic test_chess();
        do_reset();
        pass_all = 1'b0;
        for (int a = 0; a < 768; a++) send(a, 16'(a), 1'b0, a == 767);
        for (int a = 0; a < 768; a++) send(a, 16'h8000 | 16'(a), 1'b1, a == 767);
        idle(3);
        check_int("chess_writes", wr_seen, 768);
        check_int("chess_writes_pg1", wr_hi, 384);
        check_int("chess_fb0", int'(fb[0]), 16'h0000);
        check_int("chess_fb1", int'(fb[1]), 16'h8001);
        check_int("chess_done", done_seen, 1);
        check_int("chess_frame_cnt", int'(frame_cnt), 1);
        check_int("chess_err", err_seen, 0);
        check_int("chess_queue", q.size(), 0);
    endtask

    task automatic test_pass_all();
        do_reset();
        pass_all = 1'b1;
        for (int a = 0; a < 768; a++) send(a, 16'(a), 1'b0, a == 767);
        idle(2);
        check_int("pass_writes_pg0", wr_seen, 768);
        check_int("pass_err_pg0", err_seen, 0);
        check_int("pass_no_done", done_seen, 0);
        for (int a = 0; a < 768; a++) send(a, 16'h8000 | 16'(a), 1'b1, a == 767);
        check_int("pass_last_write", int'(wr_en), 1);
        check_int("pass_last_done", int'(frame_done), 1);
        check_int("pass_last_ready", int'(s_ready), 0);
        idle(2);
        check_int("pass_writes", wr_seen, 1536);
        check_int("pass_done", done_seen, 1);
        check_int("pass_frame_cnt", int'(frame_cnt), 1);
        check_int("pass_err", err_seen, 0);
        pass_all = 1'b0;
    endtask

    task automatic test_repeat_subpage();
        int bad;
        do_reset();
        pass_all = 1'b0;
        for (int a = 0; a < 768; a++) send(a, 16'(a), 1'b0, a == 767);
        for (int a = 0; a < 768; a++) send(a, 16'h0100 + 16'(a), 1'b0, a == 767);
        for (int a = 0; a < 768; a++) send(a, 16'h8000 | 16'(a), 1'b1, a == 767);
        idle(3);
        bad = 0;
        for (int a = 0; a < 768; a++)
            if (chess(10'(a)) == 1'b0 && fb[a] !== 16'h0100 + 16'(a)) bad++;
        check_int("repeat_fb_second_copy", bad, 0);
        check_int("repeat_done", done_seen, 1);
        check_int("repeat_frame_cnt", int'(frame_cnt), 1);
        check_int("repeat_err", err_seen, 0);
        check_int("repeat_writes", wr_seen, 1152);
    endtask

    task automatic test_out_of_range();
        do_reset();
        pass_all = 1'b1;
        send(800, 16'h1234, 1'b0, 1'b0);
        check_int("oor_err_pulse", int'(err_count), 1);
        check_int("oor_no_write", int'(wr_en), 0);
        idle(1);
        check_int("oor_err_clear", int'(err_count), 0);
        check_int("oor_queue", q.size(), 0);
        pass_all = 1'b0;
    endtask

    task automatic test_truncated();
        do_reset();
        pass_all = 1'b0;
        for (int a = 0; a <= 500; a++) send(a, 16'(a), 1'b0, a == 500);
        check_int("trunc_err_pulse", int'(err_count), 1);
        idle(1);
        check_int("trunc_err_clear", int'(err_count), 0);
        idle(2);
        check_int("trunc_writes", wr_seen, 250);
        check_int("trunc_err_total", err_seen, 1);
    endtask

    task automatic test_gaps_reset();
        do_reset();
        pass_all = 1'b0;
        for (int a = 0; a < 768; a++) begin
            send(a, 16'(a), 1'b0, a == 767);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        for (int a = 0; a < 300; a++) begin
            send(a, 16'h8000 | 16'(a), 1'b1, 1'b0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        // Pixel 300 belongs to subpage 1, so only the reset keeps it out of the buffer.
        s_valid = 1'b1; s_addr = 10'd300; s_data = 16'h812c; s_subpage = 1'b1; s_last = 1'b0;
        rst = 1'b1;
        tick();
        check_int("rst_squash_wr_en", int'(wr_en), 0);
        check_int("rst_frame_cnt", int'(frame_cnt), 0);
        rst = 1'b0;
        idle(1);
        done_seen = 0;
        err_seen  = 0;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 768; a++) begin
                send(a, (s == 1) ? (16'h8000 | 16'(a)) : 16'(a), s[0], a == 767);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(3);
        check_int("gaps_frame_cnt", int'(frame_cnt), 1);
        check_int("gaps_done", done_seen, 1);
        check_int("gaps_err", err_seen, 0);
        check_int("gaps_queue", q.size(), 0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        pass_all  = 1'b0;
        chk_ready = 1'b1;
        for (int f = 0; f < 256; f++) begin
            send(0, 16'(f), 1'b0, 1'b1);
            send(1, 16'h8000 | 16'(f), 1'b1, 1'b1);
            if (f == 254) begin
                idle(2);
                check_int("b2b_frame_cnt_255", int'(frame_cnt), 255);
            end
        end
        idle(3);
        chk_ready = 1'b0;
        check_int("b2b_done", done_seen, 256);
        check_int("b2b_frame_cnt_wrap", int'(frame_cnt), 0);
        check_int("b2b_err", err_seen, 512);
        check_int("b2b_writes", wr_seen, 512);
        check_int("b2b_queue", q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_last = 1'b0;
        test_reset();
        test_chess();
        test_pass_all();
        test_repeat_subpage();
        test_out_of_range();
        test_truncated();
        test_gaps_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
